frame_generator: RTL and testbench
==================================

// Module: frame_generator
// PURPOSE
//  Free-running 800x600@60 Hz (SVGA) video timing generator on the 40 MHz pixel clock.
//  Produces hsync/vsync, active-video flag and pixel/line coordinates.
//  Also provides one-line look-ahead (nextFrameActive/nextVPos) so a line-buffer
//  writer in another clock domain can prefetch the following line's pixels.
// PARAMETERS
//  H_ACTIVE   800  visible pixels per line
//  H_FP       40   horizontal front porch (pixels)
//  H_SYNC     128  hsync pulse width (pixels)
//  H_BP       88   horizontal back porch (pixels); line total 1056
//  V_ACTIVE   600  visible lines per frame
//  V_FP       1    vertical front porch (lines)
//  V_SYNC     4    vsync pulse width (lines)
//  V_BP       23   vertical back porch (lines); frame total 628
//  HSYNC_POL  1    hsync asserted level (1 = positive pulse)
//  VSYNC_POL  1    vsync asserted level
// PORTS
//  clk40            in   1   pixel clock, 40 MHz; one clock, all logic on posedge
//  rst              in   1   asynchronous, active-high reset
//  hsync            out  1   horizontal sync, HSYNC_POL during sync region
//  vsync            out  1   vertical sync, VSYNC_POL during sync lines
//  videoActive      out  1   1 when pixel is inside 800x600 visible area
//  hPos             out  10  pixel column 0..799 when active, else 0
//  vPos             out  10  line 0..599 when on visible line, else 0
//  nextFrameActive  out  1   1 when the line after the current one is visible
//  nextVPos         out  10  index of that next line (0..599) when visible, else 0
// BEHAVIOUR
//  - Internal hcnt 11b (0..1055), vcnt 10b (0..627); hcnt++ every clk; at 1055 wraps
//    to 0 and vcnt++; vcnt wraps 627->0. Frame = 663168 clocks.
//  - Line layout: active 0..799, FP 800..839, sync 840..967, BP 968..1055.
//  - Frame layout: active 0..599, FP 600, sync 601..604, BP 605..627.
//  - All outputs registered, decoded from current counters: output values at cycle
//    n+1 reflect counter position at cycle n (1-cycle latency, all outputs aligned).
//  - videoActive = (hcnt<800)&&(vcnt<600); hPos=hcnt[9:0] if active else 0.
//  - vPos = vcnt if vcnt<600 else 0 (held for whole line incl. blanking).
//  - hsync = HSYNC_POL when 840<=hcnt<=967 else ~HSYNC_POL; vsync likewise on vcnt 601..604,
//    for the full 1056 clocks of each sync line.
//  - next line L = (vcnt==627)?0:vcnt+1; nextFrameActive=(L<600); nextVPos=L if L<600 else 0.
//    Constant across the whole current line; e.g. vcnt 599 -> 0; vcnt 627 -> 1, nextVPos 0.
//  - Reset (async, any time incl. mid-frame): hcnt=vcnt=0; outputs forced to inactive:
//    videoActive=0, hPos=vPos=nextVPos=0, nextFrameActive=0, hsync=~HSYNC_POL,
//    vsync=~VSYNC_POL. First clock after release loads outputs for position (0,0).
//  - No handshakes; no stall input; counters never stop.
// STRUCTURE
//  - Shared package video_timing_pkg: H_*/V_* default constants, H_TOTAL, V_TOTAL,
//    and derived region boundaries (sync start/end) as localparams.
//  - One natural sub-module: timing_axis_counter (wrapping counter + region decode,
//    parameterised by active/fp/sync/bp), instantiated for h and v (v enabled on h wrap).
//  - Top level: output registers and look-ahead decode.
// TESTING
//  - Reset released -> after 1st edge videoActive=1, hPos=0, vPos=0, hsync=vsync=0; hPos
//    counts 0..799 over 800 clocks, then videoActive=0, hPos=0.
//  - Line timing: hsync high exactly 128 clocks starting 840 clocks after line start;
//    hsync period 1056 clocks; videoActive high 800 of every 1056 on lines 0..599.
//  - Frame timing: vsync high 4 lines (4224 clocks) starting line 601; vsync period
//    663168 clocks; no videoActive on lines 600..627.
//  - Look-ahead: line 0 -> nextFrameActive=1,nextVPos=1; line 599 -> 0,0; line 600..626 -> 0,0;
//    line 627 -> nextFrameActive=1,nextVPos=0.
//  - Async reset asserted mid-line on line 300 -> outputs go inactive immediately without
//    clock edge; after release timing restarts at (0,0) identical to first frame.
//  - Long run 3 frames: check hPos/vPos never exceed 799/599 and all outputs 1-cycle aligned.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared SVGA 800x600@60 timing constants, derived region boundaries and the
// registered output payload of the frame generator.
package video_timing_pkg;

    localparam int unsigned H_ACTIVE_DFLT = 800;
    localparam int unsigned H_FP_DFLT     = 40;
    localparam int unsigned H_SYNC_DFLT   = 128;
    localparam int unsigned H_BP_DFLT     = 88;
    localparam int unsigned V_ACTIVE_DFLT = 600;
    localparam int unsigned V_FP_DFLT     = 1;
    localparam int unsigned V_SYNC_DFLT   = 4;
    localparam int unsigned V_BP_DFLT     = 23;

    localparam logic HSYNC_POL_DFLT = 1'b1;
    localparam logic VSYNC_POL_DFLT = 1'b1;

    localparam int unsigned H_TOTAL = H_ACTIVE_DFLT + H_FP_DFLT + H_SYNC_DFLT + H_BP_DFLT;
    localparam int unsigned V_TOTAL = V_ACTIVE_DFLT + V_FP_DFLT + V_SYNC_DFLT + V_BP_DFLT;

    localparam int unsigned H_SYNC_START = H_ACTIVE_DFLT + H_FP_DFLT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DFLT - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE_DFLT + V_FP_DFLT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DFLT - 1;

    localparam int unsigned H_W   = 11;
    localparam int unsigned V_W   = 10;
    localparam int unsigned POS_W = 10;

    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic             active;
        logic [POS_W-1:0] hpos;
        logic [POS_W-1:0] vpos;
        logic             next_active;
        logic [POS_W-1:0] next_vpos;
    } timing_out_t;

endpackage

// File: rtl/timing_axis_counter.sv
// One timing axis: wrapping position counter with active/sync region decode.
// Instantiated once for pixels in a line and once for lines in a frame.
module timing_axis_counter #(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FP     = 40,
    parameter int unsigned SYNC   = 128,
    parameter int unsigned BP     = 88,
    parameter int unsigned W      = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_last_c,
    output logic         o_active_c,
    output logic         o_sync_c
);

    localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC - 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last_c ? '0 : r_cnt + W'(1);
        end
    end

    assign o_cnt      = r_cnt;
    assign o_last_c   = (r_cnt == W'(TOTAL - 1));
    assign o_active_c = (r_cnt < W'(ACTIVE));
    assign o_sync_c   = (r_cnt >= W'(SYNC_START)) && (r_cnt <= W'(SYNC_END));

endmodule

// File: rtl/frame_generator.sv
// Free-running video timing generator: h/v axis counters, one-line look-ahead
// decode and a single aligned output register stage.
module frame_generator
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DFLT,
    parameter int unsigned H_FP      = H_FP_DFLT,
    parameter int unsigned H_SYNC    = H_SYNC_DFLT,
    parameter int unsigned H_BP      = H_BP_DFLT,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DFLT,
    parameter int unsigned V_FP      = V_FP_DFLT,
    parameter int unsigned V_SYNC    = V_SYNC_DFLT,
    parameter int unsigned V_BP      = V_BP_DFLT,
    parameter logic        HSYNC_POL = HSYNC_POL_DFLT,
    parameter logic        VSYNC_POL = VSYNC_POL_DFLT
) (
    input  logic             clk40,
    input  logic             rst,
    output logic             hsync,
    output logic             vsync,
    output logic             videoActive,
    output logic [POS_W-1:0] hPos,
    output logic [POS_W-1:0] vPos,
    output logic             nextFrameActive,
    output logic [POS_W-1:0] nextVPos
);

    logic [H_W-1:0] w_hcnt;
    logic [V_W-1:0] w_vcnt;
    logic           w_h_last;
    logic           w_h_active;
    logic           w_h_sync;
    logic           w_v_last;
    logic           w_v_active;
    logic           w_v_sync;
    logic [V_W-1:0] w_next_line;
    timing_out_t    w_nxt;
    timing_out_t    r_out;

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (H_W)
    ) u_hcnt (
        .clk        (clk40),
        .rst        (rst),
        .i_en       (1'b1),
        .o_cnt      (w_hcnt),
        .o_last_c   (w_h_last),
        .o_active_c (w_h_active),
        .o_sync_c   (w_h_sync)
    );

    // Line counter advances once per completed line.
    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (V_W)
    ) u_vcnt (
        .clk        (clk40),
        .rst        (rst),
        .i_en       (w_h_last),
        .o_cnt      (w_vcnt),
        .o_last_c   (w_v_last),
        .o_active_c (w_v_active),
        .o_sync_c   (w_v_sync)
    );

    // Decode the current counter position into the next output word.
    always_comb begin
        w_nxt       = '0;
        w_next_line = w_v_last ? '0 : w_vcnt + V_W'(1);

        w_nxt.active      = w_h_active && w_v_active;
        w_nxt.hpos        = w_nxt.active ? POS_W'(w_hcnt) : '0;
        w_nxt.vpos        = w_v_active ? POS_W'(w_vcnt) : '0;
        w_nxt.hsync       = w_h_sync ? HSYNC_POL : ~HSYNC_POL;
        w_nxt.vsync       = w_v_sync ? VSYNC_POL : ~VSYNC_POL;
        w_nxt.next_active = (w_next_line < V_W'(V_ACTIVE));
        w_nxt.next_vpos   = w_nxt.next_active ? POS_W'(w_next_line) : '0;
    end

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out.hsync <= ~HSYNC_POL;
            r_out.vsync <= ~VSYNC_POL;
        end else begin
            r_out <= w_nxt;
        end
    end

    assign hsync           = r_out.hsync;
    assign vsync           = r_out.vsync;
    assign videoActive     = r_out.active;
    assign hPos            = r_out.hpos;
    assign vPos            = r_out.vpos;
    assign nextFrameActive = r_out.next_active;
    assign nextVPos        = r_out.next_vpos;

endmodule

// File: tb/tb_frame_generator.sv
// Bench for frame_generator: a full-size SVGA instance and a shrunken-timing
// instance (whole frames fit the run) checked every cycle against a position model.
module tb_frame_generator;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       active;
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       nfa;
        logic [9:0] nvp;
    } exp_t;

    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       d_hsync, d_vsync, d_act, d_nfa;
    logic [9:0] d_hpos, d_vpos, d_nvp;
    logic       s_hsync, s_vsync, s_act, s_nfa;
    logic [9:0] s_hpos, s_vpos, s_nvp;

    int ncmp  = 0;
    int nfail = 0;
    int kd    = 0;

    always #5 clk = ~clk;

    frame_generator dut_d (
        .clk40           (clk),
        .rst             (rst),
        .hsync           (d_hsync),
        .vsync           (d_vsync),
        .videoActive     (d_act),
        .hPos            (d_hpos),
        .vPos            (d_vpos),
        .nextFrameActive (d_nfa),
        .nextVPos        (d_nvp)
    );

    frame_generator #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
    ) dut_s (
        .clk40           (clk),
        .rst             (rst),
        .hsync           (s_hsync),
        .vsync           (s_vsync),
        .videoActive     (s_act),
        .hPos            (s_hpos),
        .vPos            (s_vpos),
        .nextFrameActive (s_nfa),
        .nextVPos        (s_nvp)
    );

    // Clock edges seen since reset release; outputs after edge k show frame position k-1.
    always @(posedge clk or posedge rst) begin
        if (rst) kd <= 0;
        else     kd <= kd + 1;
    end

    function automatic exp_t mk(input logic hs, input logic vs, input logic va,
                                input int hp, input int vp, input logic nf, input int nv);
        exp_t e;
        e.hsync = hs; e.vsync = vs; e.active = va;
        e.hpos = 10'(hp); e.vpos = 10'(vp); e.nfa = nf; e.nvp = 10'(nv);
        return e;
    endfunction

    function automatic exp_t model(input int k, input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb);
        int ht, vt, pos, h, v, nl;
        exp_t e;
        if (k == 0) return mk(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        pos = (k - 1) % (ht * vt);
        h   = pos % ht;
        v   = pos / ht;
        nl  = (v + 1) % vt;
        e.active = (h < ha) && (v < va);
        e.hpos   = e.active ? 10'(h) : 10'd0;
        e.vpos   = (v < va) ? 10'(v) : 10'd0;
        e.hsync  = (h >= ha + hf) && (h < ha + hf + hs);
        e.vsync  = (v >= va + vf) && (v < va + vf + vs);
        e.nfa    = (nl < va);
        e.nvp    = e.nfa ? 10'(nl) : 10'd0;
        return e;
    endfunction

    task automatic chk(input string name, input exp_t act, input exp_t exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at t=%0t k=%0d: got hs=%b vs=%b act=%b h=%0d v=%0d nfa=%b nv=%0d, want hs=%b vs=%b act=%b h=%0d v=%0d nfa=%b nv=%0d",
                     name, $time, kd, act.hsync, act.vsync, act.active, act.hpos, act.vpos, act.nfa, act.nvp,
                     exp.hsync, exp.vsync, exp.active, exp.hpos, exp.vpos, exp.nfa, exp.nvp);
        end
    endtask

    function automatic exp_t act_d();
        return mk(d_hsync, d_vsync, d_act, int'(d_hpos), int'(d_vpos), d_nfa, int'(d_nvp));
    endfunction

    function automatic exp_t act_s();
        return mk(s_hsync, s_vsync, s_act, int'(s_hpos), int'(s_vpos), s_nfa, int'(s_nvp));
    endfunction

    // Per-cycle model comparison plus hand-computed anchor points.
    always @(negedge clk) begin
        chk("svga_model", act_d(), model(kd, 800, 40, 128, 88, 600, 1, 4, 23));
        chk("small_model", act_s(), model(kd, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
        case (kd)
            1: begin
                chk("svga_first_pixel", act_d(), mk(0, 0, 1, 0, 0, 1, 1));
                chk("small_first_pixel", act_s(), mk(0, 0, 1, 0, 0, 1, 1));
            end
            800:  chk("svga_last_active", act_d(), mk(0, 0, 1, 799, 0, 1, 1));
            801:  chk("svga_front_porch", act_d(), mk(0, 0, 0, 0, 0, 1, 1));
            841:  chk("svga_hsync_start", act_d(), mk(1, 0, 0, 0, 0, 1, 1));
            968:  chk("svga_hsync_last", act_d(), mk(1, 0, 0, 0, 0, 1, 1));
            969:  chk("svga_hsync_end", act_d(), mk(0, 0, 0, 0, 0, 1, 1));
            1057: chk("svga_line1", act_d(), mk(0, 0, 1, 0, 1, 1, 2));
            default: ;
        endcase
        case (kd)
            81:  chk("small_last_vis_line", act_s(), mk(0, 0, 1, 0, 5, 0, 0));
            89:  chk("small_hblank", act_s(), mk(0, 0, 0, 0, 5, 0, 0));
            91:  chk("small_hsync", act_s(), mk(1, 0, 0, 0, 5, 0, 0));
            113: chk("small_vsync", act_s(), mk(0, 1, 0, 0, 0, 0, 0));
            145: chk("small_vsync_end", act_s(), mk(0, 0, 0, 0, 0, 0, 0));
            177: chk("small_last_line", act_s(), mk(0, 0, 0, 0, 0, 1, 0));
            193: chk("small_frame_wrap", act_s(), mk(0, 0, 1, 0, 0, 1, 1));
            default: ;
        endcase
    end

    initial begin
        rst = 1'b1;
        #1;
        chk("svga_in_reset", act_d(), mk(0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (40000) @(posedge clk);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 1055)) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("svga_async_reset", act_d(), mk(0, 0, 0, 0, 0, 0, 0));
            chk("small_async_reset", act_s(), mk(0, 0, 0, 0, 0, 0, 0));
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #2 rst = 1'b0;
            repeat (3000) @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
